// File: rtl/dp_pkg.sv
// dp_pkg: shared datapath width, operand-select encodings and packed-slice offset helper
package dp_pkg;
  localparam int DP_XLEN = 32;
  localparam int SEL_RS = 0;
  localparam int SEL_FWD_EX = 1;
  localparam int SEL_FWD_MEM = 2;
  function automatic int slice_off(input int k, input int width);
    return k * width;
  endfunction
endpackage

// File: rtl/mux_n_to_1_reg_if.sv
// mux_n_to_1_reg_if: selector bus (in_data/in_sel/in_valid/in_ready, out_data/out_sel/out_valid/out_ready, clear_err/err_sel/err_count); master drives inputs, slave is the selector
interface mux_n_to_1_reg_if #(
  parameter int WIDTH = dp_pkg::DP_XLEN,
  parameter int N_IN = 3,
  parameter int CNT_W = 8
);
  localparam int SEL_W = $clog2(N_IN);
  logic [N_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_sel;
  logic out_valid;
  logic out_ready;
  logic clear_err;
  logic err_sel;
  logic [CNT_W-1:0] err_count;
  modport master (
    output in_data, in_sel, in_valid, out_ready, clear_err,
    input in_ready, out_data, out_sel, out_valid, err_sel, err_count
  );
  modport slave (
    input in_data, in_sel, in_valid, out_ready, clear_err,
    output in_ready, out_data, out_sel, out_valid, err_sel, err_count
  );
endinterface

// File: rtl/mux_n_to_1_reg_sat_counter.sv
// sat_counter: saturating counter (clock, reset_n, inc, clr -> count); inc with clr restarts at 1
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock)
    count <= !reset_n ? '0 : inc ? (clr ? CNT_W'(1) : &count ? count : count + 1'b1) : clr ? '0 : count;
endmodule

// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg: registered N:1 word select with valid/ready, zero-fill and error tracking for bad selects (clock, reset_n, bus: mux_n_to_1_reg_if.slave)
module mux_n_to_1_reg
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_XLEN,
  parameter int N_IN = 3,
  parameter int CNT_W = 8
) (
  input logic clock,
  input logic reset_n,
  mux_n_to_1_reg_if.slave bus
);
  localparam int SEL_W = $clog2(N_IN);
  localparam int N_POW = 1 << SEL_W;
  localparam bit POW2 = N_POW == N_IN;
  logic [WIDTH-1:0] words [N_POW];
  logic accept;
  logic bad;
  for (genvar k = 0; k < N_POW; k++) begin : g_word
    if (k < N_IN) begin : g_real
      assign words[k] = bus.in_data[slice_off(k, WIDTH) +: WIDTH];
    end else begin : g_zero
      assign words[k] = '0;
    end
  end
  assign bus.in_ready = reset_n && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign bad = !POW2 && int'(bus.in_sel) >= N_IN;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_sel <= '0;
      bus.err_sel <= 1'b0;
    end else begin
      bus.out_valid <= accept || (bus.out_valid && !bus.out_ready);
      if (accept) begin
        bus.out_data <= words[bus.in_sel];
        bus.out_sel <= bus.in_sel;
      end
      bus.err_sel <= (accept && bad) || (bus.err_sel && !bus.clear_err);
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clock(clock),
    .reset_n(reset_n),
    .inc(accept && bad),
    .clr(bus.clear_err),
    .count(bus.err_count)
  );
endmodule
